// File: rtl/switch_pkg.sv
// Shared types for the switch output side: FSM states and buffered entry layout.
package switch_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, READY, SEND} out_state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } out_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/switch_out_port.sv
// Switch output port: buffers whole packets and sends them byte-serially on port_ready/port_read.
//   state | meaning
//   IDLE  | no complete packet offered; port_read ignored
//   READY | complete packet buffered and offered, nothing sent yet
//   SEND  | packet partly sent; each port_read pops one byte
module switch_out_port
  import switch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              wr_last,
  output logic              full,
  output logic              overflow,
  output logic              port_ready,
  input  logic              port_read,
  output logic [BYTE_W-1:0] port_out
);
  localparam int AW = $clog2(DEPTH);

  out_state_t          state, state_nx;
  out_entry_t          wr_entry, head;
  logic [BYTE_W:0]     head_bits;
  logic                fifo_empty, pop, push_ok;
  logic [AW:0]         fifo_count, pkt_cnt;
  logic                unused_count;

  assign wr_entry     = '{last: wr_last, data: wr_data};
  assign head         = out_entry_t'(head_bits);
  assign push_ok      = wr_en && !full;
  assign port_ready   = (state != IDLE);
  assign unused_count = ^fifo_count;

  sync_fifo #(.WIDTH($bits(out_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: if (pkt_cnt != '0) state_nx = READY;
      READY, SEND: begin
        if (port_read && !fifo_empty) begin
          pop      = 1'b1;
          state_nx = head.last ? IDLE : SEND;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pkt_cnt  <= '0;
      port_out <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      overflow <= wr_en && full;
      if (pop) port_out <= head.data;
      // A packet completing and one leaving in the same cycle cancel out.
      case ({push_ok && wr_last, pop && head.last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_switch_out_port.sv
// Scoreboard bench for switch_out_port: written bytes are queued and matched against port_out.
module tb_switch_out_port;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, wr_en, wr_last, port_read;
  logic [7:0] wr_data, port_out;
  logic       full, overflow, port_ready;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pk[$];

  always #5 clk = ~clk;

  switch_out_port #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .wr_last    (wr_last),
    .full       (full),
    .overflow   (overflow),
    .port_ready (port_ready),
    .port_read  (port_read),
    .port_out   (port_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_pkt(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      wr_en   = 1'b1;
      wr_data = b[i];
      wr_last = (i == b.size() - 1);
      exp_q.push_back({wr_last, wr_data});
      tick();
    end
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic recv_pkt(input int stall_after, input int stall_len, input int max_bytes);
    int  n;
    int  w;
    bit  done;
    n = 0; w = 0; done = 0;
    while (!port_ready && w < 50) begin
      tick();
      w++;
    end
    if (!port_ready) begin
      chk("ready_timeout", port_ready, 1);
      return;
    end
    while (!done && n < max_bytes) begin
      logic [8:0] e;
      port_read = 1'b1;
      tick();
      n++;
      if (exp_q.size() == 0) begin
        chk("sb_depth", exp_q.size(), 1);
        port_read = 1'b0;
        return;
      end
      e = exp_q.pop_front();
      chk("port_out", port_out, e[7:0]);
      chk("ready_after_byte", port_ready, !e[8]);
      done = e[8];
      if (n == stall_after && !done) begin
        port_read = 1'b0;
        repeat (stall_len) begin
          tick();
          chk("stall_hold", port_out, e[7:0]);
          chk("stall_ready", port_ready, 1);
        end
      end
    end
    port_read = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; wr_data = 8'h00; port_read = 1'b0;
    repeat (3) tick();
    chk("rst_port_out", port_out, 8'h00);
    chk("rst_ready", port_ready, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    // basic packet with write-to-offer latency
    pk = '{8'h01, 8'h02, 8'h02, 8'hAA, 8'hBB};
    write_pkt(pk);
    chk("lat_edge_n", port_ready, 0);
    tick();
    chk("lat_edge_n1", port_ready, 1);
    recv_pkt(0, 0, 16);
    tick();

    // stall after SA
    write_pkt(pk);
    recv_pkt(2, 3, 16);
    tick();

    // overflow
    for (int i = 1; i <= 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); wr_last = 1'b0;
      tick();
      if (i == 15) chk("full_15", full, 0);
      if (i == 16) begin
        chk("full_16", full, 1);
        chk("ovf_16", overflow, 0);
      end
      if (i == 17) chk("ovf_17", overflow, 1);
    end
    wr_en = 1'b0;
    tick();
    chk("ovf_pulse_end", overflow, 0);
    chk("full_hold", full, 1);
    chk("count_16", dut.fifo_count, 16);
    chk("no_pkt_ready", port_ready, 0);
    do_reset();
    chk("full_after_rst", full, 0);

    // back-to-back with a third packet written during the first
    pk = '{8'h31, 8'h32, 8'h33, 8'h34};
    write_pkt(pk);
    pk = '{8'h41, 8'h42, 8'h43, 8'h44};
    write_pkt(pk);
    pk = '{8'h51, 8'h52, 8'h53, 8'h54};
    fork
      begin
        repeat (3) recv_pkt(0, 0, 16);
      end
      begin
        for (int w = 0; w < 50 && !port_ready; w++) tick();
        write_pkt(pk);
      end
    join
    tick();
    chk("pkt_cnt_drained", dut.pkt_cnt, 0);
    chk("count_drained", dut.fifo_count, 0);
    chk("sb_drained", exp_q.size(), 0);

    // reset mid-packet
    pk = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    write_pkt(pk);
    recv_pkt(0, 0, 2);
    do_reset();
    chk("mid_rst_ready", port_ready, 0);
    chk("mid_rst_out", port_out, 8'h00);
    chk("mid_rst_full", full, 0);
    pk = '{8'h20, 8'h21, 8'h22};
    write_pkt(pk);
    recv_pkt(0, 0, 16);
    tick();

    // single-byte packet
    pk = '{8'h5A};
    write_pkt(pk);
    recv_pkt(0, 0, 16);
    tick();
    chk("final_pkt_cnt", dut.pkt_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
